// File: rtl/hr_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : hr_uart_tx
// Purpose  : 8N1 UART transmitter for heart-rate bytes. One start bit (0),
//            eight data bits LSB first, one stop bit (1), no parity. Each
//            bit is held for CLKS_PER_BIT clock cycles.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            tx_start - request to send tx_data (ignored while busy, except
//                       on the edge that ends the stop bit)
//            tx_data  - byte to send, captured on the accepting edge
//            tx       - serial line, idle high, straight from a flop
//            tx_busy  - high while a frame is in progress
//            tx_done  - one-cycle pulse on the edge that ends a frame
// Revision : 1.0 - initial release
// ============================================================================
module hr_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                    C_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [C_BAUD_W-1:0]   C_BAUD_LAST = C_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [C_BAUD_W-1:0]   C_BAUD_ONE  = C_BAUD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic [C_BAUD_W-1:0]   baud_q,    baud_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q,   shift_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  w_bit_end;

    // Last cycle of the current bit period; every state change happens here.
    assign w_bit_end = (baud_q == C_BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                if (tx_start) begin
                    state_d   = S_START;
                    shift_d   = tx_data;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    baud_d    = '0;
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + C_BAUD_ONE;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift right so the next data bit is always at [1]
                        // when it is loaded onto the line.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + C_BAUD_ONE;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    // A request on the frame-ending edge starts the next
                    // frame immediately so consecutive frames have no gap.
                    if (tx_start) begin
                        state_d   = S_START;
                        shift_d   = tx_data;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + C_BAUD_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
`default_nettype wire
